// File: rtl/easyaxi_slv_rd.sv
// easyaxi_slv_rd: AXI read-channel responder, one outstanding burst.
// Each beat returns its own aligned byte address as data.
// Optional per-beat address range check: define EASYAXI_SLV_RD_RANGE_CHK_EN
// to return DECERR (rdata 0) for beats at or above ADDR_LIMIT.
module easyaxi_slv_rd #(
  parameter int unsigned           ID_WIDTH   = 4,
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(16'h1000)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // AR channel
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ID_WIDTH-1:0]   arid,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [7:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  // R channel
  output logic                  rvalid,
  input  logic                  rready,
  output logic [ID_WIDTH-1:0]   rid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rlast
);

  localparam int unsigned MAX_SIZE = $clog2(DATA_WIDTH / 8);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef EASYAXI_SLV_RD_RANGE_CHK_EN
  localparam logic [1:0] RESP_DECERR = 2'b11;
`endif

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t                r_state;
  logic                  r_arready;
  logic                  r_rvalid;
  logic [ID_WIDTH-1:0]   r_rid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic                  r_rlast;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [7:0]            r_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_err;

  logic                  w_ar_hs;
  logic                  w_ar_err;
  logic [ADDR_WIDTH-1:0] w_first_addr;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic [7:0]            w_next_cnt;

  // Round a byte address down to the transfer-size boundary.
  function automatic logic [ADDR_WIDTH-1:0] f_align(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [2:0]            size
  );
    logic [ADDR_WIDTH-1:0] lsb_mask;
    lsb_mask = (ADDR_WIDTH'(1) << size) - ADDR_WIDTH'(1);
    return addr & ~lsb_mask;
  endfunction

  // Address of the following beat; the reserved burst type steps like INCR.
  function automatic logic [ADDR_WIDTH-1:0] f_next(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [2:0]            size,
    input logic [7:0]            len,
    input logic [1:0]            burst
  );
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    step      = ADDR_WIDTH'(1) << size;
    wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    case (burst)
      BURST_FIXED: return addr;
      BURST_WRAP:  return (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
      default:     return addr + step;
    endcase
  endfunction

  // Beat payload: the beat's own address, blanked when out of range.
  function automatic logic [DATA_WIDTH-1:0] f_data(input logic [ADDR_WIDTH-1:0] addr);
`ifdef EASYAXI_SLV_RD_RANGE_CHK_EN
    if (addr >= ADDR_LIMIT) return '0;
`endif
    return DATA_WIDTH'(addr);
  endfunction

  // Beat response: out-of-range beats decode-error ahead of request errors.
  function automatic logic [1:0] f_resp(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic                  err
  );
`ifdef EASYAXI_SLV_RD_RANGE_CHK_EN
    if (addr >= ADDR_LIMIT) return RESP_DECERR;
`endif
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

`ifndef EASYAXI_SLV_RD_RANGE_CHK_EN
  // ADDR_LIMIT only matters when the range check is built in.
  logic w_unused_limit;
  assign w_unused_limit = ^ADDR_LIMIT;
`endif

  // Request decode and beat-address stepping.
  assign w_ar_hs      = arvalid & r_arready;
  assign w_ar_err     = (arburst == BURST_RSVD) | (arsize > 3'(MAX_SIZE));
  assign w_first_addr = f_align(araddr, arsize);
  assign w_next_addr  = f_next(r_addr, r_size, r_len, r_burst);
  assign w_next_cnt   = r_cnt + 8'd1;

  // Burst FSM with registered AR/R channel outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rid     <= '0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
      r_rlast   <= 1'b0;
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rvalid  <= 1'b0;
          r_arready <= 1'b1;
          if (w_ar_hs) begin
            r_state   <= S_BURST;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rid     <= arid;
            r_addr    <= w_first_addr;
            r_len     <= arlen;
            r_size    <= arsize;
            r_burst   <= arburst;
            r_err     <= w_ar_err;
            r_cnt     <= '0;
            r_rdata   <= f_data(w_first_addr);
            r_rresp   <= f_resp(w_first_addr, w_ar_err);
            r_rlast   <= (arlen == 8'd0);
          end
        end
        S_BURST: begin
          if (r_rvalid && rready) begin
            if (r_rlast) begin
              r_state   <= S_IDLE;
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
            end else begin
              r_addr  <= w_next_addr;
              r_cnt   <= w_next_cnt;
              r_rdata <= f_data(w_next_addr);
              r_rresp <= f_resp(w_next_addr, r_err);
              r_rlast <= (w_next_cnt == r_len);
            end
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_rvalid  <= 1'b0;
          r_arready <= 1'b0;
        end
      endcase
    end
  end

  assign arready = r_arready;
  assign rvalid  = r_rvalid;
  assign rid     = r_rid;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;
  assign rlast   = r_rlast;

endmodule

// File: tb/tb_easyaxi_slv_rd.sv
// Directed bench for easyaxi_slv_rd (default parameters).
// Expectations follow EASYAXI_SLV_RD_RANGE_CHK_EN when the bench is built with it.
module tb_easyaxi_slv_rd;

  logic        clk;
  logic        rst_n;
  logic        arvalid;
  logic        arready;
  logic [3:0]  arid;
  logic [15:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  int n_vec;
  int n_err;

  easyaxi_slv_rd #(
    .ID_WIDTH   (4),
    .ADDR_WIDTH (16),
    .DATA_WIDTH (32),
    .ADDR_LIMIT (16'h1000)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .arvalid (arvalid),
    .arready (arready),
    .arid    (arid),
    .araddr  (araddr),
    .arlen   (arlen),
    .arsize  (arsize),
    .arburst (arburst),
    .rvalid  (rvalid),
    .rready  (rready),
    .rid     (rid),
    .rdata   (rdata),
    .rresp   (rresp),
    .rlast   (rlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [3:0] id, input logic [31:0] data,
                          input logic [1:0] resp, input logic last);
    chk({tag, ".rvalid"},  64'(rvalid),  64'd1);
    chk({tag, ".arready"}, 64'(arready), 64'd0);
    chk({tag, ".rid"},     64'(rid),     64'(id));
    chk({tag, ".rdata"},   64'(rdata),   64'(data));
    chk({tag, ".rresp"},   64'(rresp),   64'(resp));
    chk({tag, ".rlast"},   64'(rlast),   64'(last));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".rvalid"},  64'(rvalid),  64'd0);
    chk({tag, ".arready"}, 64'(arready), 64'd1);
  endtask

  // Present one AR request at a falling edge; returns at the falling edge after the handshake.
  task automatic send_ar(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    arvalid = 1'b1;
    arid    = id;
    araddr  = addr;
    arlen   = len;
    arsize  = size;
    arburst = burst;
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    arvalid = 1'b0;
    arid    = '0;
    araddr  = '0;
    arlen   = '0;
    arsize  = '0;
    arburst = '0;
    rready  = 1'b1;

    // Reset state
    cyc(); cyc();
    chk("rst.arready", 64'(arready), 64'd0);
    chk("rst.rvalid",  64'(rvalid),  64'd0);
    chk("rst.rlast",   64'(rlast),   64'd0);
    chk("rst.rid",     64'(rid),     64'd0);
    chk("rst.rdata",   64'(rdata),   64'd0);
    chk("rst.rresp",   64'(rresp),   64'd0);
    rst_n = 1'b1;
    chk("rel.arready_low", 64'(arready), 64'd0);
    cyc();
    chk_idle("rel");

    // INCR, 4 beats of 4 bytes
    send_ar(4'd3, 16'h0010, 8'd3, 3'd2, 2'b01);
    chk_beat("incr0", 4'd3, 32'h10, 2'b00, 1'b0); cyc();
    chk_beat("incr1", 4'd3, 32'h14, 2'b00, 1'b0); cyc();
    chk_beat("incr2", 4'd3, 32'h18, 2'b00, 1'b0); cyc();
    chk_beat("incr3", 4'd3, 32'h1C, 2'b00, 1'b1); cyc();
    chk_idle("incr.end");

    // WRAP inside a 16-byte block
    send_ar(4'd5, 16'h0038, 8'd3, 3'd2, 2'b10);
    chk_beat("wrap0", 4'd5, 32'h38, 2'b00, 1'b0); cyc();
    chk_beat("wrap1", 4'd5, 32'h3C, 2'b00, 1'b0); cyc();
    chk_beat("wrap2", 4'd5, 32'h30, 2'b00, 1'b0); cyc();
    chk_beat("wrap3", 4'd5, 32'h34, 2'b00, 1'b1); cyc();
    chk_idle("wrap.end");

    // Backpressure on beat 0
    rready = 1'b0;
    send_ar(4'd6, 16'h0100, 8'd1, 3'd2, 2'b01);
    chk_beat("bp0a", 4'd6, 32'h100, 2'b00, 1'b0); cyc();
    chk_beat("bp0b", 4'd6, 32'h100, 2'b00, 1'b0); cyc();
    chk_beat("bp0c", 4'd6, 32'h100, 2'b00, 1'b0); cyc();
    chk_beat("bp0d", 4'd6, 32'h100, 2'b00, 1'b0);
    rready = 1'b1;
    cyc();
    chk_beat("bp1", 4'd6, 32'h104, 2'b00, 1'b1); cyc();
    chk_idle("bp.end");

    // FIXED, 2-byte beats
    send_ar(4'd7, 16'h0042, 8'd2, 3'd1, 2'b00);
    chk_beat("fix0", 4'd7, 32'h42, 2'b00, 1'b0); cyc();
    chk_beat("fix1", 4'd7, 32'h42, 2'b00, 1'b0); cyc();
    chk_beat("fix2", 4'd7, 32'h42, 2'b00, 1'b1); cyc();
    chk_idle("fix.end");

    // Reserved burst type: SLVERR, stepped as INCR
    send_ar(4'd8, 16'h0042, 8'd2, 3'd1, 2'b11);
    chk_beat("rsv0", 4'd8, 32'h42, 2'b10, 1'b0); cyc();
    chk_beat("rsv1", 4'd8, 32'h44, 2'b10, 1'b0); cyc();
    chk_beat("rsv2", 4'd8, 32'h46, 2'b10, 1'b1); cyc();
    chk_idle("rsv.end");

    // Oversized transfer: SLVERR, single beat, address aligned to 8
    send_ar(4'd2, 16'h0023, 8'd0, 3'd3, 2'b01);
    chk_beat("big0", 4'd2, 32'h20, 2'b10, 1'b1); cyc();
    chk_idle("big.end");

    // Unaligned start address
    send_ar(4'd4, 16'h0013, 8'd1, 3'd2, 2'b01);
    chk_beat("ual0", 4'd4, 32'h10, 2'b00, 1'b0); cyc();
    chk_beat("ual1", 4'd4, 32'h14, 2'b00, 1'b1); cyc();
    chk_idle("ual.end");

    // Crossing ADDR_LIMIT
    send_ar(4'd1, 16'h0FFC, 8'd1, 3'd2, 2'b01);
    chk_beat("lim0", 4'd1, 32'hFFC, 2'b00, 1'b0); cyc();
`ifdef EASYAXI_SLV_RD_RANGE_CHK_EN
    chk_beat("lim1", 4'd1, 32'h0, 2'b11, 1'b1); cyc();
`else
    chk_beat("lim1", 4'd1, 32'h1000, 2'b00, 1'b1); cyc();
`endif
    chk_idle("lim.end");

    // Address wraps modulo 2^16
    send_ar(4'd11, 16'hFFFC, 8'd1, 3'd2, 2'b01);
`ifdef EASYAXI_SLV_RD_RANGE_CHK_EN
    chk_beat("mod0", 4'd11, 32'h0, 2'b11, 1'b0); cyc();
`else
    chk_beat("mod0", 4'd11, 32'hFFFC, 2'b00, 1'b0); cyc();
`endif
    chk_beat("mod1", 4'd11, 32'h0, 2'b00, 1'b1); cyc();
    chk_idle("mod.end");

    // Reset during beat 1 of an 8-beat burst
    send_ar(4'd9, 16'h0200, 8'd7, 3'd2, 2'b01);
    chk_beat("mrst0", 4'd9, 32'h200, 2'b00, 1'b0); cyc();
    chk_beat("mrst1", 4'd9, 32'h204, 2'b00, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst.rvalid",  64'(rvalid),  64'd0);
    chk("mrst.arready", 64'(arready), 64'd0);
    chk("mrst.rlast",   64'(rlast),   64'd0);
    cyc();
    rst_n = 1'b1;
    chk("mrst.rel_rvalid",  64'(rvalid),  64'd0);
    chk("mrst.rel_arready", 64'(arready), 64'd0);
    cyc();
    chk_idle("mrst.idle");
    cyc();
    chk_idle("mrst.idle2");
    send_ar(4'd1, 16'h0040, 8'd0, 3'd2, 2'b01);
    chk_beat("post0", 4'd1, 32'h40, 2'b00, 1'b1); cyc();
    chk_idle("post.end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/easyaxi_slv_rd.md
EASYAXI_SLV_RD -- requirements
Module: easyaxi_slv_rd

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4, AXI ID width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, AXI byte-address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, R data width.
REQ-004 SHALL have parameter ADDR_LIMIT, default 16'h1000, first out-of-range byte address.
REQ-005 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-006 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports: arvalid in 1; arready out 1; arid in ID_WIDTH; araddr in ADDR_WIDTH; arlen in 8; arsize in 3; arburst in 2.
REQ-008 SHALL have ports: rvalid out 1; rready in 1; rid out ID_WIDTH; rdata out DATA_WIDTH; rresp out 2; rlast out 1.

Function
REQ-009 SHALL be an AXI read-channel responder with one outstanding burst, FSM states IDLE and BURST.
REQ-010 In IDLE, arready SHALL be 1 and rvalid 0; AR handshake (arvalid&arready) SHALL capture arid/araddr/arlen/arsize/arburst and go to BURST.
REQ-011 In BURST, arready SHALL be 0; first rvalid SHALL assert in the cycle after the AR handshake (latency 1).
REQ-012 Beat count SHALL be arlen+1 (1..256); rlast SHALL be 1 only on beat index == arlen.
REQ-013 Beat advances only on rvalid&rready; while rvalid&!rready, rid/rdata/rresp/rlast SHALL hold stable.
REQ-014 After the rlast handshake, rvalid SHALL be 0 and arready 1 in the next cycle (IDLE); no back-to-back beat of a new burst in that cycle.
REQ-015 Beat address: FIXED(00) constant; INCR(01) += 1<<arsize; WRAP(10) increments and wraps within aligned block of (arlen+1)<<arsize bytes.
REQ-016 First beat address SHALL be araddr aligned down to 1<<arsize; address arithmetic SHALL be ADDR_WIDTH wide, modulo 2^ADDR_WIDTH.
REQ-017 rdata SHALL equal the beat's aligned byte address zero-extended (or truncated) to DATA_WIDTH.
REQ-018 rresp SHALL be 2'b00 OKAY by default; arburst 11 SHALL return 2'b10 SLVERR on every beat, address handled as INCR.
REQ-019 arsize greater than log2(DATA_WIDTH/8) SHALL return SLVERR on every beat.
REQ-020 rid SHALL equal the captured arid on every beat.

Reset
REQ-021 On rst_n low, asynchronously: state IDLE, arready 0, rvalid 0, rlast 0, rid 0, rdata 0, rresp 0, beat counter 0.
REQ-022 arready SHALL rise in the first clk edge after rst_n deassertion.
REQ-023 Reset mid-burst SHALL abandon the burst; no R beat SHALL be issued for it after reset.

Configuration
REQ-024 Macro EASYAXI_SLV_RD_RANGE_CHK_EN: when defined, beats with aligned address >= ADDR_LIMIT SHALL return rresp 2'b11 DECERR and rdata 0, checked per beat.
REQ-025 Without EASYAXI_SLV_RD_RANGE_CHK_EN, ADDR_LIMIT SHALL be ignored and all beats follow REQ-017/018/019.

Verification
REQ-026 INCR: arid=3, araddr=0x0010, arlen=3, arsize=2, rready=1 -> 4 beats rdata 0x10,0x14,0x18,0x1C, rid=3, rlast on 4th, rresp 00.
REQ-027 WRAP: araddr=0x0038, arlen=3, arsize=2 -> rdata 0x38,0x3C,0x30,0x34, rlast on 4th.
REQ-028 Backpressure: INCR arlen=1, rready low 3 cycles on beat 0 -> rdata 0x..., rid, rlast held stable; arready stays 0 until cycle after final handshake.
REQ-029 FIXED arlen=2 araddr=0x0042 arsize=1 -> 3 beats rdata 0x42; arburst=11 -> rresp 10 on all beats.
REQ-030 RANGE_CHK_EN defined, ADDR_LIMIT=0x1000, INCR araddr=0x0FFC arlen=1 arsize=2 -> beat0 rdata 0xFFC OKAY, beat1 rdata 0 DECERR.
REQ-031 rst_n pulsed low during beat 1 of arlen=7 -> rvalid 0 immediately, arready 1 one edge after release, next burst starts cleanly.
